// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multicycle ALU.
// Optional divider is controlled by the ALU_MC_DIV_EN macro (see alu_mc.sv).
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_MULU = 4'b1000,
    OP_DIVU = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Selects which iterative step the shared datapath performs.
  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_t;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one step of the iterative datapath shared by MULU and DIVU.
//   MUL: {acc,q} holds partial product / remaining multiplier; conditional
//        add of m then a 1-bit right shift of the {acc,q} pair.
//   DIV: restoring division; {acc,q} shifted left by one, m subtracted from
//        the top half when it fits, quotient bit shifted into q.
// The divide step exists only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  iter_mode_t       i_mode,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_mul_sum;

  assign w_mul_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);

`ifdef ALU_MC_DIV_EN
  // The partial remainder needs one extra bit after the left shift.
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_diff;

  assign w_rem  = {i_acc, i_q[WIDTH-1]};
  assign w_diff = w_rem - {1'b0, i_m};
`endif

  // Select the next accumulator/shift-register pair for the active mode.
  always_comb begin
    o_acc = w_mul_sum[WIDTH:1];
    o_q   = {w_mul_sum[0], i_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    if (i_mode == ITER_DIV) begin
      o_acc = w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], ~w_diff[WIDTH]};
    end
`else
    if (i_mode != ITER_MUL) begin
      o_acc = i_acc;
      o_q   = i_q;
    end
`endif
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with registered results behind valid/ready.
// Optional feature macro: ALU_MC_DIV_EN (enables DIVU; otherwise DIVU is an
// illegal code returning y=0, hi=0 in one cycle).
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high (in_ready is high only in IDLE). A result is
// delivered on a rising edge where out_valid and out_ready are both high
// (out_valid is high only in DONE); y/hi/zero/ltez stay stable until then.
// The producer must hold in_valid and its operands until accepted.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ltez,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW:0]     r_cnt;
  iter_mode_t       r_mode;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ltez;

  alu_op_t          w_op;
  logic             w_is_iter;
  iter_mode_t       w_mode_sel;
  logic             w_accept;
  logic             w_last_step;
  logic             w_load;
  logic [WIDTH-1:0] w_sc_y;
  logic [WIDTH-1:0] w_res_y;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_q_n;

  assign w_op = alu_op_t'(alu_control);

`ifdef ALU_MC_DIV_EN
  assign w_is_iter  = (w_op == OP_MULU) || (w_op == OP_DIVU);
  assign w_mode_sel = (w_op == OP_DIVU) ? ITER_DIV : ITER_MUL;
`else
  assign w_is_iter  = (w_op == OP_MULU);
  assign w_mode_sel = ITER_MUL;
`endif

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_last_step = (r_state == BUSY) && (r_cnt == (SHW+1)'(1));
  assign w_load      = (w_accept && !w_is_iter) || w_last_step;
  assign w_res_y     = (r_state == BUSY) ? w_q_n   : w_sc_y;
  assign w_res_hi    = (r_state == BUSY) ? w_acc_n : '0;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .i_mode (r_mode),
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_m    (r_m),
    .o_acc  (w_acc_n),
    .o_q    (w_q_n)
  );

  // Single-cycle operations, evaluated from the live inputs at accept.
  always_comb begin
    w_sc_y = '0;
    case (w_op)
      OP_AND:  w_sc_y = a & b;
      OP_OR:   w_sc_y = a | b;
      OP_ADD:  w_sc_y = a + b;
      OP_SUB:  w_sc_y = a - b;
      OP_SLT:  w_sc_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  w_sc_y = b << shamt;
      OP_SRL:  w_sc_y = b >> shamt;
      OP_SRA:  w_sc_y = WIDTH'($signed(b) >>> shamt);
      default: w_sc_y = '0;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_is_iter ? BUSY : DONE;
      end
      BUSY: begin
        if (w_last_step) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Iterative datapath registers: loaded at accept, stepped while BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_mode <= ITER_MUL;
      r_acc  <= '0;
      r_q    <= '0;
      r_m    <= '0;
    end else if (w_accept && w_is_iter) begin
      r_cnt  <= (SHW+1)'(WIDTH);
      r_mode <= w_mode_sel;
      r_acc  <= '0;
      r_q    <= a;
      r_m    <= b;
    end else if (r_state == BUSY) begin
      r_cnt  <= r_cnt - (SHW+1)'(1);
      r_acc  <= w_acc_n;
      r_q    <= w_q_n;
    end
  end

  // Result registers with flags derived from the final y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y    <= '0;
      r_hi   <= '0;
      r_zero <= 1'b0;
      r_ltez <= 1'b0;
    end else if (w_load) begin
      r_y    <= w_res_y;
      r_hi   <= w_res_hi;
      r_zero <= (w_res_y == '0);
      r_ltez <= (w_res_y == '0) || w_res_y[WIDTH-1];
    end
  end

  assign y         = r_y;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign ltez      = r_ltez;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
// Expectations for DIVU depend on ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;
  localparam int ITER_LAT = W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     alu_control;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic [W-1:0]   hi;
  logic           zero;
  logic           ltez;
  state_t         dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi_q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .hi          (hi),
    .zero        (zero),
    .ltez        (ltez),
    .dbg_state   (dbg_state)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op, wait for its result, check it against the scoreboard, hand it off.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [SHW-1:0] sh,
                       input int exp_lat, input logic [W-1:0] ey, input logic [W-1:0] ehi);
    int           guard;
    int           lat;
    logic         rdy_busy;
    logic [W-1:0] qy;
    logic [W-1:0] qhi;
    exp_q.push_back(ey);
    exp_hi_q.push_back(ehi);
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    a = ia; b = ib; alu_control = op; shamt = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready || dbg_state != BUSY) rdy_busy = 1'b1;
      a = $urandom;
      b = $urandom;
      shamt = SHW'($urandom_range(0, W-1));
      tick();
      lat++;
    end
    qy  = exp_q.pop_front();
    qhi = exp_hi_q.pop_front();
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_not_ready"}, rdy_busy, 0);
    chk({tag, "_y"}, y, qy);
    chk({tag, "_hi"}, hi, qhi);
    chk({tag, "_zero"}, zero, (qy == '0));
    chk({tag, "_ltez"}, ltez, (qy == '0) || qy[W-1]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  // Main sequence
  initial begin
    logic bp_bad;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_control = '0; shamt = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ltez", ltez, 0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b1;
    tick();

    do_op("sub",  4'b0110, 32'd5, 32'd7, 5'd0, 1, 32'hFFFF_FFFE, 32'h0);
    do_op("and",  4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 1, 32'h0000_F000, 32'h0);
    do_op("or",   4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 1, 32'h0000_FFF0, 32'h0);
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'h0, 32'h0);
    do_op("sll",  4'b0100, 32'h0, 32'd1, 5'd31, 1, 32'h8000_0000, 32'h0);
    do_op("sra",  4'b1101, 32'h0, 32'h8000_0010, 5'd4, 1, 32'hF800_0001, 32'h0);
    do_op("srl",  4'b0101, 32'h0, 32'h8000_0010, 5'd4, 1, 32'h0800_0001, 32'h0);
    do_op("slt",  4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'h1, 32'h0);
    do_op("slt_f", 4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 32'h0);
    do_op("illegal", 4'b0011, 32'h1234, 32'h5678, 5'd0, 1, 32'h0, 32'h0);
    do_op("mulu", 4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0, ITER_LAT, 32'hFFFF_FFFE, 32'h1);
    do_op("mulu2", 4'b1000, 32'd12345, 32'd678, 5'd0, ITER_LAT, 32'd8369910, 32'h0);
`ifdef ALU_MC_DIV_EN
    do_op("divu", 4'b1001, 32'd100, 32'd7, 5'd0, ITER_LAT, 32'd14, 32'd2);
    do_op("divu0", 4'b1001, 32'd9, 32'd0, 5'd0, ITER_LAT, 32'hFFFF_FFFF, 32'd9);
`else
    do_op("divu_off", 4'b1001, 32'd100, 32'd7, 5'd0, 1, 32'h0, 32'h0);
`endif

    // Backpressure: result held while a new op waits.
    a = '0; b = '0; alu_control = 4'b0010; in_valid = 1'b1;
    tick();
    chk("bp_valid", out_valid, 1);
    a = 32'd1; b = 32'd1;
    bp_bad = 1'b0;
    repeat (5) begin
      tick();
      if (!out_valid || y != '0 || !zero || !ltez || in_ready) bp_bad = 1'b1;
    end
    chk("bp_stable", bp_bad, 0);
    chk("bp_y", y, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_handoff_valid", out_valid, 0);
    chk("bp_handoff_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_y", y, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-BUSY aborts the multiply.
    a = 32'hFFFF_FFFF; b = 32'd2; alu_control = 4'b1000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("rb_busy", dbg_state, BUSY);
    reset = 1'b0;
    #1;
    chk("rb_out_valid", out_valid, 0);
    chk("rb_y", y, 0);
    chk("rb_hi", hi, 0);
    chk("rb_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 5'd0, 1, 32'd7, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
